// File: rtl/ahblite_busmatrix_outputstage_itcm_pkg.sv
// Shared encodings for the ITCM output stage: AHB transfer types, grant owner
// and data-phase owner.
package ahblite_busmatrix_outputstage_itcm_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic {
        G_ICODE = 1'b0,
        G_DCODE = 1'b1
    } grant_e;

    typedef enum logic [1:0] {
        DOWN_NONE  = 2'b00,
        DOWN_ICODE = 2'b01,
        DOWN_DCODE = 2'b10
    } down_e;

    function automatic logic is_burst(input logic sel, input logic [1:0] trans);
        return sel & ((trans == HTRANS_SEQ) || (trans == HTRANS_BUSY));
    endfunction

    function automatic logic is_nonseq(input logic sel, input logic [1:0] trans);
        return sel & (trans == HTRANS_NONSEQ);
    endfunction

endpackage

// File: rtl/ahblite_busmatrix_arbiter_itcm.sv
// Address-phase arbiter for the ITCM port: DCODE has fixed priority, a burst in
// progress keeps its owner, and the grant parks on the last owner when idle.
module ahblite_busmatrix_arbiter_itcm
    import ahblite_busmatrix_outputstage_itcm_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_hready,
    input  logic       i_sel_icode,
    input  logic [1:0] i_trans_icode,
    input  logic       i_sel_dcode,
    input  logic [1:0] i_trans_dcode,
    output grant_e     o_grant
);

    grant_e r_grant;
    logic   w_burst_owner;

    always_comb begin
        w_burst_owner = (r_grant == G_DCODE) ? is_burst(i_sel_dcode, i_trans_dcode)
                                             : is_burst(i_sel_icode, i_trans_icode);
    end

    // Wait states freeze arbitration entirely.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_grant <= G_ICODE;
        end else if (i_hready && !w_burst_owner) begin
            if (is_nonseq(i_sel_dcode, i_trans_dcode)) begin
                r_grant <= G_DCODE;
            end else if (is_nonseq(i_sel_icode, i_trans_icode)) begin
                r_grant <= G_ICODE;
            end
        end
    end

    assign o_grant = r_grant;

endmodule

// File: rtl/ahblite_busmatrix_outputstage_itcm.sv
// ITCM output stage of the ICODE/DCODE bus matrix: arbitrates the two masters,
// muxes the owner's address phase and tracks the data-phase owner.
module ahblite_busmatrix_outputstage_itcm
    import ahblite_busmatrix_outputstage_itcm_pkg::*;
(
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL_Decoder_ICODE_ITCM,
    input  logic [31:0] HADDR_ICODE,
    input  logic [1:0]  HTRANS_ICODE,
    input  logic        HWRITE_ICODE,
    input  logic [2:0]  HSIZE_ICODE,
    input  logic [3:0]  HPROT_ICODE,
    input  logic        HSEL_Decoder_DCODE_ITCM,
    input  logic [31:0] HADDR_DCODE,
    input  logic [1:0]  HTRANS_DCODE,
    input  logic        HWRITE_DCODE,
    input  logic [2:0]  HSIZE_DCODE,
    input  logic [3:0]  HPROT_DCODE,
    input  logic [31:0] HWDATA_DCODE,
    input  logic        HREADYOUT_ITCM,
    output logic        ACTIVE_Outputstage_ITCM_ICODE,
    output logic        ACTIVE_Outputstage_ITCM_DCODE,
    output logic        HREADYOUT_Outputstage_ITCM,
    output logic        HSEL_ITCM,
    output logic [31:0] HADDR_ITCM,
    output logic [1:0]  HTRANS_ITCM,
    output logic        HWRITE_ITCM,
    output logic [2:0]  HSIZE_ITCM,
    output logic [3:0]  HPROT_ITCM,
    output logic [31:0] HWDATA_ITCM,
    output logic        HREADY_ITCM
);

    grant_e     w_grant;
    down_e      r_down;
    logic       w_own_sel;
    logic [1:0] w_own_trans;
    logic       w_own_req;

    ahblite_busmatrix_arbiter_itcm u_arbiter (
        .i_clk         (HCLK),
        .i_rst         (HRESET),
        .i_hready      (HREADYOUT_ITCM),
        .i_sel_icode   (HSEL_Decoder_ICODE_ITCM),
        .i_trans_icode (HTRANS_ICODE),
        .i_sel_dcode   (HSEL_Decoder_DCODE_ITCM),
        .i_trans_dcode (HTRANS_DCODE),
        .o_grant       (w_grant)
    );

    always_comb begin
        if (w_grant == G_DCODE) begin
            w_own_sel   = HSEL_Decoder_DCODE_ITCM;
            w_own_trans = HTRANS_DCODE;
            HADDR_ITCM  = HADDR_DCODE;
            HWRITE_ITCM = HWRITE_DCODE;
            HSIZE_ITCM  = HSIZE_DCODE;
            HPROT_ITCM  = HPROT_DCODE;
        end else begin
            w_own_sel   = HSEL_Decoder_ICODE_ITCM;
            w_own_trans = HTRANS_ICODE;
            HADDR_ITCM  = HADDR_ICODE;
            HWRITE_ITCM = HWRITE_ICODE;
            HSIZE_ITCM  = HSIZE_ICODE;
            HPROT_ITCM  = HPROT_ICODE;
        end
        w_own_req   = w_own_sel & w_own_trans[1];
        HSEL_ITCM   = w_own_sel;
        HTRANS_ITCM = w_own_sel ? w_own_trans : HTRANS_IDLE;
    end

    // Data-phase owner follows the address phase accepted on each ready cycle.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_down <= DOWN_NONE;
        end else if (HREADYOUT_ITCM) begin
            if (!w_own_req) begin
                r_down <= DOWN_NONE;
            end else if (w_grant == G_DCODE) begin
                r_down <= DOWN_DCODE;
            end else begin
                r_down <= DOWN_ICODE;
            end
        end
    end

    assign ACTIVE_Outputstage_ITCM_ICODE = (w_grant == G_ICODE);
    assign ACTIVE_Outputstage_ITCM_DCODE = (w_grant == G_DCODE);
    assign HREADY_ITCM                   = HREADYOUT_ITCM;
    assign HREADYOUT_Outputstage_ITCM    = (r_down != DOWN_NONE) ? HREADYOUT_ITCM : 1'b1;
    assign HWDATA_ITCM                   = (r_down == DOWN_DCODE) ? HWDATA_DCODE : 32'h0;

endmodule
